// File: rtl/pwm_compare_if.sv
// Duty-update handshake between a duty-cycle source and pwm_compare.
// The master presents a new duty value with a one-cycle write strobe and
// sees a one-cycle acknowledge when that value becomes the active duty.
interface pwm_compare_if #(
    parameter int CW = 8
);
    logic [CW-1:0] duty_in;
    logic          duty_wr;
    logic          duty_ack;

    modport master (
        output duty_in,
        output duty_wr,
        input  duty_ack
    );

    modport slave (
        input  duty_in,
        input  duty_wr,
        output duty_ack
    );
endinterface

// File: rtl/pwm_compare.sv
// PWM comparator slaved to an external free-running counter.
// Tracks the upstream count for wraps and discontinuities, double-buffers
// duty updates so they only take effect on a period boundary, and gates the
// waveform with a small run/drain state machine so a stop request always
// completes the current period.
module pwm_compare #(
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CW-1:0]   cnt,
    input  logic            en,
    pwm_compare_if.slave    duty_bus,
    output logic            pwm_out,
    output logic            wrap,
    output logic [1:0]      state,
    output logic            seq_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_last_q, cnt_last_d;
    logic           cnt_seen_q, cnt_seen_d;
    logic [CW-1:0]  duty_act_q, duty_act_d;
    logic [CW-1:0]  duty_pend_q, duty_pend_d;
    logic           pend_q, pend_d;
    logic           pwm_q, pwm_d;
    logic           wrap_q, wrap_d;
    logic           ack_q, ack_d;
    logic           seq_err_q, seq_err_d;

    logic [CW:0]    cnt_succ;
    logic           wrap_cond;
    logic           seq_cond;
    logic           activate;

    // Detect wrap and count discontinuity from the previous and current count.
    always_comb begin
        cnt_succ  = {1'b0, cnt_last_q} + {{CW{1'b0}}, 1'b1};
        // Carry out of the successor means the previous count was all ones.
        wrap_cond = cnt_seen_q && cnt_succ[CW] && (cnt == '0);
        seq_cond  = cnt_seen_q && (cnt != cnt_succ[CW-1:0]);
        activate  = wrap_cond && pend_q;
    end

    // Duty double buffer: activation at wrap first, then a same-cycle write
    // refills the pending slot so it is never lost.
    always_comb begin
        duty_act_d  = duty_act_q;
        duty_pend_d = duty_pend_q;
        pend_d      = pend_q;
        if (activate) begin
            duty_act_d = duty_pend_q;
            pend_d     = 1'b0;
        end
        if (duty_bus.duty_wr) begin
            duty_pend_d = duty_bus.duty_in;
            pend_d      = 1'b1;
        end
    end

    // Run control: arm until a period boundary, drain to the next boundary on stop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (en) state_d = ARM;
            ARM: begin
                if (!en)            state_d = IDLE;
                else if (wrap_cond) state_d = RUN;
            end
            RUN:   if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en)             state_d = RUN;
                else if (wrap_cond) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and tracking next-values; the compare uses the post-wrap state and
    // duty so the first cycle of a period already reflects a just-activated duty.
    always_comb begin
        pwm_d      = ((state_d == RUN) || (state_d == DRAIN)) && (cnt < duty_act_d);
        wrap_d     = wrap_cond;
        ack_d      = activate;
        seq_err_d  = seq_err_q | seq_cond;
        cnt_last_d = cnt;
        cnt_seen_d = 1'b1;
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_last_q  <= '0;
            cnt_seen_q  <= 1'b0;
            duty_act_q  <= '0;
            duty_pend_q <= '0;
            pend_q      <= 1'b0;
            pwm_q       <= 1'b0;
            wrap_q      <= 1'b0;
            ack_q       <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_last_q  <= cnt_last_d;
            cnt_seen_q  <= cnt_seen_d;
            duty_act_q  <= duty_act_d;
            duty_pend_q <= duty_pend_d;
            pend_q      <= pend_d;
            pwm_q       <= pwm_d;
            wrap_q      <= wrap_d;
            ack_q       <= ack_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign pwm_out           = pwm_q;
    assign wrap              = wrap_q;
    assign state             = state_q;
    assign seq_err           = seq_err_q;
    assign duty_bus.duty_ack = ack_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare: directed period scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_pwm_compare;

    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;
    localparam int S_IDLE = 0, S_ARM = 1, S_RUN = 2, S_DRAIN = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [CW-1:0] cnt = '0;
    logic          pwm_out, wrap, seq_err;
    logic [1:0]    state;

    pwm_compare_if #(.CW(CW)) bus();

    pwm_compare #(.CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cnt      (cnt),
        .en       (en),
        .duty_bus (bus.slave),
        .pwm_out  (pwm_out),
        .wrap     (wrap),
        .state    (state),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    // Behavioural model
    int m_state, m_dact, m_dpend, m_last;
    bit m_pend, m_seen, m_pwm, m_wrap, m_ack, m_seq;

    int checks = 0;
    int passes = 0;
    int hi = 0;
    int acks = 0;

    function automatic logic [5:0] dv();
        return {state, pwm_out, wrap, bus.duty_ack, seq_err};
    endfunction

    function automatic logic [5:0] mv();
        logic [1:0] s;
        s = 2'(m_state);
        return {s, m_pwm, m_wrap, m_ack, m_seq};
    endfunction

    // Advance the model by the inputs present at the coming edge, then clock.
    task automatic step();
        int  c;
        bit  w;
        c = int'(cnt);
        if (reset) begin
            m_state = S_IDLE; m_dact = 0; m_dpend = 0; m_last = 0;
            m_pend = 0; m_seen = 0; m_pwm = 0; m_wrap = 0; m_ack = 0; m_seq = 0;
        end else begin
            w = m_seen && (m_last == MAXV) && (c == 0);
            if (m_seen && (((m_last + 1) % (MAXV + 1)) != c)) m_seq = 1;
            m_wrap = w;
            m_ack  = w && m_pend;
            if (w && m_pend) begin
                m_dact = m_dpend;
                m_pend = 0;
            end
            if (bus.duty_wr) begin
                m_dpend = int'(bus.duty_in);
                m_pend  = 1;
            end
            case (m_state)
                S_IDLE:  if (en) m_state = S_ARM;
                S_ARM:   m_state = !en ? S_IDLE : (w ? S_RUN : S_ARM);
                S_RUN:   if (!en) m_state = S_DRAIN;
                default: m_state = en ? S_RUN : (w ? S_IDLE : S_DRAIN);
            endcase
            m_pwm  = (m_state == S_RUN || m_state == S_DRAIN) && (c < m_dact);
            m_seen = 1;
            m_last = c;
        end
        @(posedge clk);
        #1;
        hi   += int'(pwm_out);
        acks += int'(bus.duty_ack);
        cnt = cnt + 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; bus.duty_wr = 1'b0; bus.duty_in = '0; cnt = 8'd250;
        for (int i = 0; i < 3; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL rst_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (dv() !== 6'b0) $display("FAIL reset_outs act=%b exp=%b", dv(), 6'b0); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_arm_to_run();
        en = 1'b1;
        step(); checks++; if (dv() !== mv()) $display("FAIL arm_cyc act=%b exp=%b", dv(), mv()); else passes++;
        checks++; if (state !== 2'd1) $display("FAIL enter_arm act=%0d exp=1", state); else passes++;
        bus.duty_wr = 1'b1; bus.duty_in = 8'd64;
        step(); checks++; if (dv() !== mv()) $display("FAIL arm_cyc act=%b exp=%b", dv(), mv()); else passes++;
        bus.duty_wr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL arm_cyc act=%b exp=%b", dv(), mv()); else passes++;
            if (wrap) break;
        end
        checks++;
        if ({wrap, bus.duty_ack, state} !== 4'b1110)
            $display("FAIL first_wrap act=%b exp=%b", {wrap, bus.duty_ack, state}, 4'b1110);
        else passes++;
        hi = int'(pwm_out);
        for (int i = 0; i < 255; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL run64_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (hi !== 64) $display("FAIL duty64_high act=%0d exp=64", hi); else passes++;
    endtask

    task automatic test_duty_change();
        hi = 0; acks = 0;
        for (int i = 0; i < 100; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL chg_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        bus.duty_wr = 1'b1; bus.duty_in = 8'd200;
        step(); checks++; if (dv() !== mv()) $display("FAIL chg_cyc act=%b exp=%b", dv(), mv()); else passes++;
        bus.duty_wr = 1'b0;
        for (int i = 0; i < 155; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL chg_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (hi !== 64 || acks !== 0) $display("FAIL old_duty_hold act=%0d/%0d exp=64/0", hi, acks); else passes++;
        step(); checks++; if (dv() !== mv()) $display("FAIL chg_cyc act=%b exp=%b", dv(), mv()); else passes++;
        checks++; if ({wrap, bus.duty_ack} !== 2'b11) $display("FAIL ack_with_wrap act=%b exp=11", {wrap, bus.duty_ack}); else passes++;
        hi = int'(pwm_out);
        for (int i = 0; i < 255; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL chg_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (hi !== 200) $display("FAIL duty200_high act=%0d exp=200", hi); else passes++;
    endtask

    task automatic test_last_write_wins();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL lww_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        bus.duty_wr = 1'b1; bus.duty_in = 8'd10;
        step(); checks++; if (dv() !== mv()) $display("FAIL lww_cyc act=%b exp=%b", dv(), mv()); else passes++;
        bus.duty_wr = 1'b0;
        for (int i = 0; i < 39; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL lww_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        bus.duty_wr = 1'b1; bus.duty_in = 8'd20;
        step(); checks++; if (dv() !== mv()) $display("FAIL lww_cyc act=%b exp=%b", dv(), mv()); else passes++;
        bus.duty_wr = 1'b0;
        for (int i = 0; i < 205; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL lww_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        step(); checks++; if (dv() !== mv()) $display("FAIL lww_cyc act=%b exp=%b", dv(), mv()); else passes++;
        hi = int'(pwm_out);
        for (int i = 0; i < 255; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL lww_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (acks !== 1) $display("FAIL single_ack act=%0d exp=1", acks); else passes++;
        checks++; if (hi !== 20) $display("FAIL duty20_high act=%0d exp=20", hi); else passes++;
    endtask

    task automatic test_seq_err();
        for (int i = 0; i < 38; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL seq_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        cnt = '0;
        step(); checks++; if (dv() !== mv()) $display("FAIL seq_cyc act=%b exp=%b", dv(), mv()); else passes++;
        checks++; if (seq_err !== 1'b1) $display("FAIL seq_err_set act=%b exp=1", seq_err); else passes++;
        for (int i = 0; i < 300; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL seq_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (seq_err !== 1'b1) $display("FAIL seq_err_sticky act=%b exp=1", seq_err); else passes++;
        reset = 1'b1;
        step(); checks++; if (seq_err !== 1'b0) $display("FAIL seq_err_clear act=%b exp=0", seq_err); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_drain();
        en = 1'b1; bus.duty_wr = 1'b1; bus.duty_in = 8'd100;
        step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        bus.duty_wr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
            if (wrap) break;
        end
        checks++; if (state !== 2'd2) $display("FAIL run_again act=%0d exp=2", state); else passes++;
        for (int i = 0; i < 149; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        en = 1'b0;
        step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        checks++; if (state !== 2'd3) $display("FAIL enter_drain act=%0d exp=3", state); else passes++;
        for (int i = 0; i < 105; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        checks++; if ({wrap, state, pwm_out} !== 4'b1000) $display("FAIL drain_idle act=%b exp=1000", {wrap, state, pwm_out}); else passes++;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (hi !== 0) $display("FAIL idle_low act=%0d exp=0", hi); else passes++;
        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
            if (wrap) break;
        end
        hi = int'(pwm_out);
        for (int i = 0; i < 149; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        en = 1'b0;
        step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        for (int i = 0; i < 49; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        en = 1'b1;
        step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        checks++; if (state !== 2'd2) $display("FAIL drain_resume act=%0d exp=2", state); else passes++;
        for (int i = 0; i < 55; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (hi !== 100) $display("FAIL no_gap_high act=%0d exp=100", hi); else passes++;
        step(); checks++; if (dv() !== mv()) $display("FAIL drn_cyc act=%b exp=%b", dv(), mv()); else passes++;
        checks++; if ({wrap, state} !== 3'b110) $display("FAIL stay_run act=%b exp=110", {wrap, state}); else passes++;
    endtask

    task automatic test_duty_extremes();
        bus.duty_wr = 1'b1; bus.duty_in = 8'd0;
        step(); checks++; if (dv() !== mv()) $display("FAIL ext_cyc act=%b exp=%b", dv(), mv()); else passes++;
        bus.duty_wr = 1'b0;
        for (int i = 0; i < 254; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL ext_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        // Write coincident with an activating wrap: 0 activates, 255 stays pending.
        bus.duty_wr = 1'b1; bus.duty_in = 8'd255;
        step(); checks++; if (dv() !== mv()) $display("FAIL ext_cyc act=%b exp=%b", dv(), mv()); else passes++;
        bus.duty_wr = 1'b0;
        checks++; if (bus.duty_ack !== 1'b1) $display("FAIL ack_duty0 act=%b exp=1", bus.duty_ack); else passes++;
        hi = int'(pwm_out);
        for (int i = 0; i < 255; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL ext_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (hi !== 0) $display("FAIL duty0_high act=%0d exp=0", hi); else passes++;
        bus.duty_wr = 1'b1; bus.duty_in = 8'd0;
        step(); checks++; if (dv() !== mv()) $display("FAIL ext_cyc act=%b exp=%b", dv(), mv()); else passes++;
        bus.duty_wr = 1'b0;
        checks++; if (bus.duty_ack !== 1'b1) $display("FAIL ack_kept_write act=%b exp=1", bus.duty_ack); else passes++;
        hi = int'(pwm_out);
        for (int i = 0; i < 255; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL ext_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (hi !== 255) $display("FAIL duty255_high act=%0d exp=255", hi); else passes++;
        for (int i = 0; i < 128; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL ext_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        reset = 1'b1; bus.duty_wr = 1'b1; bus.duty_in = 8'd77;
        step(); checks++; if (dv() !== 6'b0) $display("FAIL mid_reset act=%b exp=%b", dv(), 6'b0); else passes++;
        reset = 1'b0; bus.duty_wr = 1'b0;
        acks = 0;
        for (int i = 0; i < 300; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL ext_cyc act=%b exp=%b", dv(), mv()); else passes++;
            if (wrap) break;
        end
        hi = int'(pwm_out);
        for (int i = 0; i < 255; i++) begin
            step(); checks++; if (dv() !== mv()) $display("FAIL ext_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        checks++; if (hi !== 0 || acks !== 0) $display("FAIL pend_discarded act=%0d/%0d exp=0/0", hi, acks); else passes++;
    endtask

    task automatic test_random();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) en = ~en;
            bus.duty_wr = ($urandom_range(39) == 0);
            bus.duty_in = CW'($urandom);
            reset = ($urandom_range(1499) == 0);
            if ($urandom_range(1999) == 0) cnt = CW'($urandom);
            step(); checks++; if (dv() !== mv()) $display("FAIL rnd_cyc act=%b exp=%b", dv(), mv()); else passes++;
        end
        reset = 1'b0; bus.duty_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arm_to_run();
        test_duty_change();
        test_last_write_wins();
        test_seq_err();
        test_drain();
        test_duty_extremes();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
